axil_crossbar_sm_rd: RTL
========================

// Module: axil_crossbar_sm_rd
// PURPOSE
// - Slave-to-master read return path of the AXI-Lite interconnect, one instance per slave port.
// - Records which master owns each accepted AR and routes R beats back to that master in issue order.
// - Tracks outstanding reads in a tag FIFO and raises ar_block when no tag slot is free.
// PARAMETERS
// - NUMBER_MASTER    axil_pkg   number of master ports (package constant)
// - AXI_DATA_WIDTH   axil_pkg   R data width (package constant)
// - MAX_OUTSTANDING  4          tag FIFO depth, power of two, >=2
// PORTS
// - aclk              in   1                    clock, all logic on rising edge
// - areset            in   1                    synchronous reset, active-high
// - grant_rd          in   NUMBER_MASTER        one-hot AR grant from the read arbiter
// - s_axil_arvalid    in   1                    slave-side AR valid, as driven to the slave
// - s_axil_arready    in   1                    slave-side AR ready, from the slave
// - ar_block          out  1                    tag FIFO full; arbiter must hold arvalid low
// - s_axil_rdata      in   AXI_DATA_WIDTH       slave R data
// - s_axil_rresp      in   2                    slave R response
// - s_axil_rvalid     in   1                    slave R valid
// - s_axil_rready     out  1                    R ready to slave
// - m_axil_rdata      out  AXI_DATA_WIDTH x NM  R data per master (unpacked array)
// - m_axil_rresp      out  2 x NM               R response per master (unpacked array)
// - m_axil_rvalid     out  NUMBER_MASTER        R valid per master
// - m_axil_rready     in   NUMBER_MASTER        R ready per master
// - outstanding       out  $clog2(MAX_OUTSTANDING)+1  accepted ARs not yet returned
// BEHAVIOUR
// - Reset: tag FIFO empty, outstanding=0, ar_block=0, s_axil_rready=0, all m_axil_rvalid=0,
//   m_axil_rdata/rresp=0; in-flight reads discarded (slave is reset in the same cycle).
// - Push: on s_axil_arvalid & s_axil_arready & !full, push index of grant_rd; non-one-hot
//   grant -> lowest set bit; grant_rd==0 -> no push. Push while full is dropped.
// - ar_block = (outstanding==MAX_OUTSTANDING), combinational from count; a same-cycle pop
//   does not release it until the next cycle.
// - Route: head = FIFO head index. When !empty: m_axil_rvalid[head]=s_axil_rvalid,
//   s_axil_rready=m_axil_rready[head]; all other m_axil_rvalid=0.
// - Data/resp: broadcast to every master lane when !empty; only head lane has rvalid high.
// - Pop: on s_axil_rvalid & s_axil_rready (slave-side R handshake).
// - Empty: s_axil_rready=0, all m_axil_rvalid=0; stray slave rvalid held, never accepted.
// - Simultaneous push+pop: count unchanged, pointers both advance, wrap modulo depth.
// - Ordering: responses strictly in AR acceptance order; back-to-back beats 1/cycle.
// - Latency (no option): 0 cycles slave R -> master R, fully combinational path.
// - Master stall (rready=0): slave held, s_axil_rready=0, head unchanged; AXI stability kept.
// CONFIGURATION
// - AXIL_SM_RD_REG_EN defined: 2-entry skid buffer between slave R and master R.
//   s_axil_rready = skid not full (registered); pop on slave-side handshake; each skid entry
//   carries data, resp, master index; m_axil_rvalid driven from skid head; +1 cycle latency,
//   1 beat/cycle sustained; reset empties skid.
// - Not defined: combinational routing as above, no extra storage.
// TESTING
// - Single read M1 (NM=2): AR hs grant=2'b10, R rdata=32'hA5A5_0001 -> m_rvalid=2'b10,
//   m_axil_rdata[1]=32'hA5A5_0001, outstanding 1->0.
// - Order: ARs from M0,M1,M0 then 3 R beats D0,D1,D2 -> D0 to M0, D1 to M1, D2 to M0.
// - Full: 4 ARs no R -> outstanding=4, ar_block=1; one R pop -> ar_block=0 next cycle.
// - Backpressure: head M1 rready=0 for 3 cycles with s_rvalid=1 -> s_rready=0, data stable,
//   handshake on 4th cycle.
// - Empty stray: s_rvalid=1 with empty FIFO -> s_rready=0, m_rvalid=0 for 5 cycles.
// - Reset mid-op: outstanding=3, assert areset 1 cycle -> outstanding=0, all valids 0;
//   with AXIL_SM_RD_REG_EN also check +1 latency and 1 beat/cycle streaming.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI-Lite interconnect constants: master count and data width.
package axil_pkg;
  localparam int NUMBER_MASTER  = 2;
  localparam int AXI_DATA_WIDTH = 32;
endpackage

// File: rtl/axil_crossbar_sm_rd.sv
// Slave-to-master R return path: tags each accepted AR with its master and steers R beats back in order.
// Optional macro AXIL_SM_RD_REG_EN inserts a 2-entry skid buffer between slave R and master R.
module axil_crossbar_sm_rd
  import axil_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUMBER_MASTER-1:0]  grant_rd,
  input  logic                      s_axil_arvalid,
  input  logic                      s_axil_arready,
  output logic                      ar_block,
  input  logic [AXI_DATA_WIDTH-1:0] s_axil_rdata,
  input  logic [1:0]                s_axil_rresp,
  input  logic                      s_axil_rvalid,
  output logic                      s_axil_rready,
  output logic [AXI_DATA_WIDTH-1:0] m_axil_rdata [NUMBER_MASTER],
  output logic [1:0]                m_axil_rresp [NUMBER_MASTER],
  output logic [NUMBER_MASTER-1:0]  m_axil_rvalid,
  input  logic [NUMBER_MASTER-1:0]  m_axil_rready,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding
);

  localparam int IDX_W = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1;
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] tag_mem_q [MAX_OUTSTANDING];
  logic [IDX_W-1:0] tag_mem_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             grant_any;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] head_idx;
  logic             full, empty, push, pop;

  // Lowest set bit wins when the grant is not one-hot.
  always_comb begin
    grant_idx = '0;
    for (int i = NUMBER_MASTER - 1; i >= 0; i--) begin
      if (grant_rd[i]) grant_idx = IDX_W'(i);
    end
  end

  assign grant_any   = |grant_rd;
  assign full        = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty       = (count_q == '0);
  assign push        = s_axil_arvalid & s_axil_arready & ~full & grant_any;
  assign pop         = s_axil_rvalid & s_axil_rready;
  assign head_idx    = tag_mem_q[rd_ptr_q];
  assign ar_block    = full;
  assign outstanding = count_q;

  always_comb begin
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      tag_mem_d[wr_ptr_q] = grant_idx;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) tag_mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      tag_mem_q <= tag_mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

`ifdef AXIL_SM_RD_REG_EN
  logic [AXI_DATA_WIDTH-1:0] skid_data_q [2];
  logic [AXI_DATA_WIDTH-1:0] skid_data_d [2];
  logic [1:0]                skid_resp_q [2];
  logic [1:0]                skid_resp_d [2];
  logic [IDX_W-1:0]          skid_idx_q  [2];
  logic [IDX_W-1:0]          skid_idx_d  [2];
  logic                      skid_wr_q, skid_wr_d, skid_rd_q, skid_rd_d;
  logic [1:0]                skid_cnt_q, skid_cnt_d;
  logic                      skid_valid, skid_pop;
  logic [IDX_W-1:0]          skid_head;

  // Ready depends only on registered occupancy, breaking the master-to-slave ready path.
  assign s_axil_rready = ~empty & (skid_cnt_q != 2'd2);
  assign skid_valid    = (skid_cnt_q != 2'd0);
  assign skid_head     = skid_idx_q[skid_rd_q];
  assign skid_pop      = skid_valid & m_axil_rready[skid_head];

  always_comb begin
    skid_data_d = skid_data_q;
    skid_resp_d = skid_resp_q;
    skid_idx_d  = skid_idx_q;
    skid_wr_d   = skid_wr_q;
    skid_rd_d   = skid_rd_q;
    skid_cnt_d  = skid_cnt_q;
    if (pop) begin
      skid_data_d[skid_wr_q] = s_axil_rdata;
      skid_resp_d[skid_wr_q] = s_axil_rresp;
      skid_idx_d[skid_wr_q]  = head_idx;
      skid_wr_d              = ~skid_wr_q;
    end
    if (skid_pop) skid_rd_d = ~skid_rd_q;
    case ({pop, skid_pop})
      2'b10:   skid_cnt_d = skid_cnt_q + 2'd1;
      2'b01:   skid_cnt_d = skid_cnt_q - 2'd1;
      default: skid_cnt_d = skid_cnt_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < 2; i++) begin
        skid_data_q[i] <= '0;
        skid_resp_q[i] <= '0;
        skid_idx_q[i]  <= '0;
      end
      skid_wr_q  <= 1'b0;
      skid_rd_q  <= 1'b0;
      skid_cnt_q <= 2'd0;
    end else begin
      skid_data_q <= skid_data_d;
      skid_resp_q <= skid_resp_d;
      skid_idx_q  <= skid_idx_d;
      skid_wr_q   <= skid_wr_d;
      skid_rd_q   <= skid_rd_d;
      skid_cnt_q  <= skid_cnt_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUMBER_MASTER; gi++) begin : g_lane
      assign m_axil_rvalid[gi] = skid_valid & (skid_head == IDX_W'(gi));
      assign m_axil_rdata[gi]  = skid_valid ? skid_data_q[skid_rd_q] : '0;
      assign m_axil_rresp[gi]  = skid_valid ? skid_resp_q[skid_rd_q] : 2'b00;
    end
  endgenerate
`else
  // Zero-latency path: head tag steers valid forward and ready back.
  assign s_axil_rready = ~empty & m_axil_rready[head_idx];

  generate
    for (genvar gi = 0; gi < NUMBER_MASTER; gi++) begin : g_lane
      assign m_axil_rvalid[gi] = ~empty & s_axil_rvalid & (head_idx == IDX_W'(gi));
      assign m_axil_rdata[gi]  = empty ? '0 : s_axil_rdata;
      assign m_axil_rresp[gi]  = empty ? 2'b00 : s_axil_rresp;
    end
  endgenerate
`endif

endmodule
